clean_status_display: RTL and testbench
=======================================

# clean_status_display

Display and alert driver for the range-hood self-clean function. It consumes the `cleaning`, `countdown` and `done` status outputs of the self-clean controller. It renders the remaining time as M.SS on a 4-digit multiplexed seven-segment display, and it flashes "donE" with a buzzer when cleaning completes. It sits between the self-clean controller and the board display/buzzer pins, in the fast `clk` domain.

## Interface
- `CLK_HZ`, default 100_000_000: `clk` frequency in Hz.
- `SCAN_HZ`, default 1000: digit-switch rate; each digit is enabled for CLK_HZ/SCAN_HZ cycles.
- `BLINK_HZ`, default 2: blink rate of "donE" and buzzer; half-period is CLK_HZ/(2*BLINK_HZ) cycles.
- `DONE_SHOW_S`, default 5: duration of the completion display in seconds (DONE_SHOW_S*CLK_HZ cycles).
- `clk` in 1: system clock; the block has one clock.
- `rst` in 1: asynchronous, active-high reset.
- `cleaning` in 1: level, high while self-clean runs; asynchronous to `clk` phase.
- `countdown` in 8: remaining seconds, unsigned binary 0..255.
- `done` in 1: completion flag; only its rising edge is used.
- `seg_out` out 8: segments {dp,g,f,e,d,c,b,a}, active high.
- `seg_en` out 4: one-hot digit enable, bit 3 = leftmost, active high.
- `buzzer` out 1: buzzer drive, active high.

## Operation
- **Input synchronisation**
  - `cleaning`, `done` and each `countdown` bit pass through 2-flop synchronizers.
  - A `done` edge is detected on the synchronized value, using the previous synchronized sample.
  - `countdown` is accepted only when two consecutive synchronized samples are equal. The accepted value is held in `cd_hold`; a single-cycle glitch is never accepted.
- **Converter** (sequential, started when `cd_hold` changes or on entry to RUN):
  - Minutes: repeated subtraction of 60, at most 4 steps. M = cd_hold/60 (0..4), S = cd_hold%60.
  - Tens/ones of S: repeated subtraction of 10, at most 5 steps.
  - Results are committed atomically to the display registers at completion, so digits never show a partial value.
  - If `cd_hold` changes mid-conversion, the conversion restarts on the next cycle.
- **Mode FSM**, states BLANK, RUN, DONE_SHOW:
  - BLANK: `seg_en`=0, `seg_out`=0, `buzzer`=0. Goes to RUN if synced `cleaning`=1; goes to DONE_SHOW on a `done` rising edge.
  - RUN: digits show 3:'0', 2:M with dp on (acts as the colon), 1:S tens, 0:S ones. Goes to DONE_SHOW on a `done` rising edge, or to BLANK when `cleaning` falls without `done`.
  - DONE_SHOW: digits show "donE" (3..0). The display and `buzzer` are both on during the blink-on half and both off during the blink-off half. After DONE_SHOW_S seconds it goes to BLANK. Goes to RUN immediately if `cleaning`=1.
  - Priority when events coincide: `cleaning`=1 > `done` rising edge > timeout.
  - The blink phase and show timer restart at 0 (on-phase first) on every entry to DONE_SHOW. A second `done` edge in DONE_SHOW restarts the timer.
- **Segment codes**
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Letters: d=5E, o=5C, n=54, E=79.
  - dp adds 80.

## Timing
- **Reset**: every output is 0. FSM is BLANK, scan index 0, `cd_hold`=0, all timers 0. Reset takes effect immediately at any point, including mid-conversion or mid-DONE_SHOW.
- **Scan**
  - Index order is 0,1,2,3 and wraps to 0; each digit is held CLK_HZ/SCAN_HZ cycles.
  - `seg_en` and `seg_out` are registered and change on the same edge; there is no overlap between digits.
- **Latency**
  - `countdown` change to display registers updated: at most 3 (sync + stability) + 10 (conversion) + 1 cycles, i.e. 14.
  - `cleaning` or `done` edge to FSM state change: 3 cycles.
- **Countdown range**
  - `countdown`=0 in RUN displays 0.00.
  - 255 displays 4.15.
  - Values above 180 are displayed without clamping.

## Test plan
Benches use CLK_HZ=1000, SCAN_HZ=100 (10 cycles/digit), BLINK_HZ=50 (10-cycle half-period) and DONE_SHOW_S=1 (1000 cycles).

- Reset asserted with all inputs toggling -> `seg_out`=00, `seg_en`=0, `buzzer`=0; after release with `cleaning`=0 -> still blank.
- `cleaning`=1, `countdown`=180 -> within 14 cycles digits 3..0 = 3F, CF, 3F, 3F. Then `countdown`=125 -> 3F, DB, 3F, 6D. Then 59 -> 3F, BF, 6D, 6F. Then 255 -> 3F, E6, 06, 6D.
- `countdown` pulses 180->7->180 for 1 cycle during RUN -> display stays 0.3.00 throughout.
- `cleaning` falls with `done` rising in the same cycle -> DONE_SHOW. Digits show 5E, 5C, 54, 79 for 10 cycles, then blank for 10, repeating. `buzzer` follows the same pattern. 1000 cycles after entry -> BLANK, `buzzer`=0.
- `cleaning` rises 300 cycles into DONE_SHOW -> RUN within 3 cycles, with `buzzer`=0. A `done` edge at cycle 500 of a later DONE_SHOW -> the timer restarts and the block blanks 1000 cycles after that edge.
- `rst` asserted mid-RUN and mid-conversion -> outputs are 0 immediately. After release with `cleaning`=1, `countdown`=90 -> display shows 0.1.30.

Source files
------------

// File: rtl/clean_status_display_if.sv
// Status/display bundle between the self-clean controller, this driver and the board pins.
// Ports: cleaning/countdown/done come from the controller; seg_out/seg_en/buzzer go to the pins.
// slave = the display driver, master = whoever supplies status and watches the pins.
interface clean_status_display_if;
  logic       cleaning;
  logic [7:0] countdown;
  logic       done;
  logic [7:0] seg_out;
  logic [3:0] seg_en;
  logic       buzzer;

  modport master (output cleaning, countdown, done, input seg_out, seg_en, buzzer);
  modport slave  (input cleaning, countdown, done, output seg_out, seg_en, buzzer);
endinterface

// File: rtl/clean_status_display.sv
// Self-clean display/alert driver: shows remaining time as M.SS on a 4-digit muxed display,
// flashes "donE" with the buzzer on completion. Ports: clk, rst (async, active high), bus (slave).
// Latency: 3 cycles from cleaning/done edge to mode change, <=14 cycles from countdown to digits.
// No backpressure; outputs are free-running.
module clean_status_display #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int BLINK_HZ    = 2,
  parameter int DONE_SHOW_S = 5
) (
  input logic                   clk,
  input logic                   rst,
  clean_status_display_if.slave bus
);
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int HALF_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SHOW_DIV = DONE_SHOW_S * CLK_HZ;
  localparam int SCAN_W   = $clog2(SCAN_DIV + 1);
  localparam int HALF_W   = $clog2(HALF_DIV + 1);
  localparam int SHOW_W   = $clog2(SHOW_DIV + 1);

  localparam logic [1:0] ST_BLANK = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // ---------------- input synchronisation ----------------
  logic [1:0] clean_sy, done_sy;
  logic       done_prev;
  logic [7:0] cd_s1, cd_s2, cd_prev, cd_hold;
  logic       clean_s, done_rise, cd_load;

  assign clean_s   = clean_sy[1];
  assign done_rise = done_sy[1] & ~done_prev;
  // A new countdown is taken only once it has been seen on two consecutive synced samples.
  assign cd_load   = (cd_s2 == cd_prev) && (cd_s2 != cd_hold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clean_sy  <= '0;
      done_sy   <= '0;
      done_prev <= 1'b0;
      cd_s1     <= '0;
      cd_s2     <= '0;
      cd_prev   <= '0;
      cd_hold   <= '0;
    end else begin
      clean_sy  <= {clean_sy[0], bus.cleaning};
      done_sy   <= {done_sy[0], bus.done};
      done_prev <= done_sy[1];
      cd_s1     <= bus.countdown;
      cd_s2     <= cd_s1;
      cd_prev   <= cd_s2;
      if (cd_load) cd_hold <= cd_s2;
    end
  end

  // ---------------- mode FSM ----------------
  logic [1:0]        state, nxt;
  logic [SHOW_W-1:0] show_cnt;
  logic [HALF_W-1:0] blink_cnt;
  logic              blink_on, show_end, enter_run, enter_done, show_restart;

  assign show_end = (show_cnt == SHOW_W'(SHOW_DIV - 1));

  // Priority everywhere: cleaning high > done edge > timeout.
  always_comb begin
    nxt = state;
    case (state)
      ST_BLANK: if (clean_s) nxt = ST_RUN; else if (done_rise) nxt = ST_DONE;
      ST_RUN:   if (!clean_s) nxt = done_rise ? ST_DONE : ST_BLANK;
      ST_DONE:  if (clean_s) nxt = ST_RUN; else if (!done_rise && show_end) nxt = ST_BLANK;
      default:  nxt = ST_BLANK;
    endcase
  end

  assign enter_run    = (nxt == ST_RUN) && (state != ST_RUN);
  assign enter_done   = (nxt == ST_DONE) && (state != ST_DONE);
  assign show_restart = enter_done || ((state == ST_DONE) && (nxt == ST_DONE) && done_rise);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_BLANK;
      show_cnt  <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else begin
      state <= nxt;
      if (show_restart) show_cnt <= '0;
      else if ((state == ST_DONE) && !show_end) show_cnt <= show_cnt + 1'b1;
      // Blink always starts with the on half when DONE_SHOW is entered.
      if (enter_done) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == HALF_W'(HALF_DIV - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // ---------------- seconds -> M, S tens, S ones ----------------
  // Subtract 60 while possible, then 10; the remainder is the ones digit.
  // Display registers are only written on completion so a half-done result is never shown.
  logic       busy;
  logic [7:0] rem;
  logic [2:0] m_acc, t_acc, disp_m, disp_t;
  logic [3:0] disp_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      rem    <= '0;
      m_acc  <= '0;
      t_acc  <= '0;
      disp_m <= '0;
      disp_t <= '0;
      disp_o <= '0;
    end else if (cd_load || enter_run) begin
      busy  <= 1'b1;
      rem   <= cd_load ? cd_s2 : cd_hold;
      m_acc <= '0;
      t_acc <= '0;
    end else if (busy) begin
      if (rem >= 8'd60) begin
        rem   <= rem - 8'd60;
        m_acc <= m_acc + 3'd1;
      end else if (rem >= 8'd10) begin
        rem   <= rem - 8'd10;
        t_acc <= t_acc + 3'd1;
      end else begin
        busy   <= 1'b0;
        disp_m <= m_acc;
        disp_t <= t_acc;
        disp_o <= rem[3:0];
      end
    end
  end

  // ---------------- scan and output registers ----------------
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 8'h3F;  4'd1: return 8'h06;  4'd2: return 8'h5B;  4'd3: return 8'h4F;
      4'd4: return 8'h66;  4'd5: return 8'h6D;  4'd6: return 8'h7D;  4'd7: return 8'h07;
      4'd8: return 8'h7F;  4'd9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        scan_idx;
  logic [7:0]        pat, seg_out_r;
  logic [3:0]        seg_en_r;
  logic              buzzer_r, lit;

  assign lit = (state == ST_RUN) || ((state == ST_DONE) && blink_on);

  always_comb begin
    pat = 8'h00;
    if (state == ST_DONE) begin
      case (scan_idx)
        2'd3:    pat = 8'h5E;
        2'd2:    pat = 8'h5C;
        2'd1:    pat = 8'h54;
        default: pat = 8'h79;
      endcase
    end else begin
      case (scan_idx)
        2'd3:    pat = seg_code(4'd0);
        2'd2:    pat = seg_code({1'b0, disp_m}) | 8'h80;  // dp doubles as the colon
        2'd1:    pat = seg_code({1'b0, disp_t});
        default: pat = seg_code(disp_o);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      scan_idx  <= '0;
      seg_out_r <= '0;
      seg_en_r  <= '0;
      buzzer_r  <= 1'b0;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seg_en_r  <= lit ? (4'b0001 << scan_idx) : 4'b0000;
      seg_out_r <= lit ? pat : 8'h00;
      buzzer_r  <= (state == ST_DONE) && blink_on;
    end
  end

  assign bus.seg_out = seg_out_r;
  assign bus.seg_en  = seg_en_r;
  assign bus.buzzer  = buzzer_r;
endmodule

// File: tb/tb_clean_status_display.sv
module tb_clean_status_display;
  localparam int CLK_HZ = 1000, SCAN_HZ = 100, BLINK_HZ = 50, DONE_SHOW_S = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  clean_status_display_if bus();

  clean_status_display #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ),
                         .DONE_SHOW_S(DONE_SHOW_S)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cur_cd = 0;
  logic [7:0] dig_lut [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  logic [7:0] let_lut [4]  = '{8'h79, 8'h54, 8'h5C, 8'h5E};  // index = digit position, 3 = leftmost

  // Reference: what digit position idx shows for cd seconds in RUN (M.SS with leading '0').
  function automatic logic [7:0] exp_run(input int cd, input int idx);
    int m = cd / 60;
    int s = cd % 60;
    case (idx)
      3:       return dig_lut[0];
      2:       return dig_lut[m] | 8'h80;
      1:       return dig_lut[s / 10];
      default: return dig_lut[s % 10];
    endcase
  endfunction

  function automatic int idx_of(input logic [3:0] en);
    case (en)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.cleaning  = 1'($urandom_range(0, 1));
      bus.countdown = 8'($urandom);
      bus.done      = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({bus.seg_out, bus.seg_en, bus.buzzer} !== 13'd0) begin
        fails++;
        $display("FAIL reset_outputs: got seg_out=%h seg_en=%b buzzer=%b, want all 0",
                 bus.seg_out, bus.seg_en, bus.buzzer);
      end
    end
    tick();
    rst = 1'b0; bus.cleaning = 1'b0; bus.done = 1'b0; bus.countdown = 8'd42;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.seg_out, bus.seg_en, bus.buzzer} !== 13'd0) begin
        fails++;
        $display("FAIL idle_blank: got seg_out=%h seg_en=%b buzzer=%b, want all 0",
                 bus.seg_out, bus.seg_en, bus.buzzer);
      end
    end
    tick();
  endtask

  // Apply one countdown in RUN and check every digit over a full scan round after settling.
  task automatic test_countdown_value(input int cd);
    logic [3:0] seen = 4'h0;
    int idx;
    bus.countdown = 8'(cd);
    cur_cd = cd;
    repeat (15) @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      idx = idx_of(bus.seg_en);
      checks++;
      if (idx < 0 || bus.seg_out !== exp_run(cd, idx) || bus.buzzer !== 1'b0) begin
        fails++;
        $display("FAIL run_digit cd=%0d: got seg_en=%b seg_out=%h buzzer=%b, want digit %0d = %h buzzer 0",
                 cd, bus.seg_en, bus.seg_out, bus.buzzer, idx, (idx < 0) ? 8'h00 : exp_run(cd, idx));
      end else begin
        seen[idx] = 1'b1;
      end
    end
    checks++;
    if (seen !== 4'hF) begin
      fails++;
      $display("FAIL run_coverage cd=%0d: digits seen %b, want 1111", cd, seen);
    end
    tick();
  endtask

  task automatic test_run_values();
    bus.cleaning = 1'b1;
    test_countdown_value(180);
    test_countdown_value(125);
    test_countdown_value(59);
    test_countdown_value(255);
  endtask

  task automatic test_scan();
    logic [3:0] prev;
    int run = 1, changes = 0;
    @(negedge clk);
    prev = bus.seg_en;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (bus.seg_en !== prev) begin
        checks++;
        if (bus.seg_en !== {prev[2:0], prev[3]}) begin
          fails++;
          $display("FAIL scan_order: got seg_en=%b after %b, want %b", bus.seg_en, prev, {prev[2:0], prev[3]});
        end
        if (changes > 0) begin
          checks++;
          if (run !== 10) begin
            fails++;
            $display("FAIL scan_hold: digit held %0d cycles, want 10", run);
          end
        end
        changes++;
        run  = 1;
        prev = bus.seg_en;
      end else begin
        run++;
      end
    end
    checks++;
    if (changes < 8) begin
      fails++;
      $display("FAIL scan_progress: %0d digit switches, want at least 8", changes);
    end
    tick();
  endtask

  task automatic test_glitch();
    int idx;
    test_countdown_value(180);
    bus.countdown = 8'd7;
    tick();
    bus.countdown = 8'd180;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      idx = idx_of(bus.seg_en);
      checks++;
      if (idx < 0 || bus.seg_out !== exp_run(180, idx)) begin
        fails++;
        $display("FAIL glitch_hold: got seg_en=%b seg_out=%h, want 0.3.00 digit %0d",
                 bus.seg_en, bus.seg_out, idx);
      end
    end
    tick();
  endtask

  task automatic test_random();
    test_countdown_value(0);
    repeat (6) test_countdown_value(int'($urandom_range(0, 255)));
  endtask

  // DONE_SHOW: state changes 3 edges after the input edge, pins one edge later.
  task automatic test_done_show();
    logic on;
    int idx;
    bus.cleaning = 1'b0;
    bus.done     = 1'b1;
    for (int j = 0; j <= 1030; j++) begin
      @(negedge clk);
      on = (j >= 4) && (j <= 1003) && ((((j - 4) / 10) % 2) == 0);
      checks++;
      if (bus.buzzer !== on) begin
        fails++;
        $display("FAIL done_buzzer j=%0d: got %b, want %b", j, bus.buzzer, on);
      end
      if (j >= 4) begin
        checks++;
        if (on) begin
          idx = idx_of(bus.seg_en);
          if (idx < 0 || bus.seg_out !== let_lut[idx]) begin
            fails++;
            $display("FAIL done_letter j=%0d: got seg_en=%b seg_out=%h, want donE letter",
                     j, bus.seg_en, bus.seg_out);
          end
        end else if (bus.seg_en !== 4'h0 || bus.seg_out !== 8'h00) begin
          fails++;
          $display("FAIL done_blank j=%0d: got seg_en=%b seg_out=%h, want 0 and 00",
                   j, bus.seg_en, bus.seg_out);
        end
      end
    end
    tick();
    bus.done = 1'b0;
  endtask

  task automatic test_done_cancel();
    int idx;
    repeat (5) tick();
    bus.done = 1'b1;
    repeat (50) tick();
    bus.done = 1'b0;
    repeat (250) tick();
    bus.cleaning = 1'b1;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (j >= 4) begin
        idx = idx_of(bus.seg_en);
        checks++;
        if (bus.buzzer !== 1'b0 || idx < 0 || bus.seg_out !== exp_run(cur_cd, idx)) begin
          fails++;
          $display("FAIL cancel_to_run j=%0d: got buzzer=%b seg_en=%b seg_out=%h, want buzzer 0 and RUN digits",
                   j, bus.buzzer, bus.seg_en, bus.seg_out);
        end
      end
    end
    tick();
  endtask

  task automatic test_done_restart();
    int on_late = 0;
    bus.cleaning = 1'b0;
    bus.done     = 1'b1;
    repeat (100) tick();
    bus.done = 1'b0;
    repeat (400) tick();
    bus.done = 1'b1;
    for (int j = 0; j <= 1030; j++) begin
      @(negedge clk);
      checks++;
      if (bus.buzzer !== (bus.seg_en != 4'h0)) begin
        fails++;
        $display("FAIL restart_sync j=%0d: got buzzer=%b seg_en=%b, want buzzer equal to display on",
                 j, bus.buzzer, bus.seg_en);
      end
      if (j >= 510 && j <= 1000 && bus.buzzer === 1'b1) on_late++;
      if (j >= 1004) begin
        checks++;
        if ({bus.seg_out, bus.seg_en, bus.buzzer} !== 13'd0) begin
          fails++;
          $display("FAIL restart_timeout j=%0d: got seg_out=%h seg_en=%b buzzer=%b, want blank",
                   j, bus.seg_out, bus.seg_en, bus.buzzer);
        end
      end
    end
    checks++;
    if (on_late == 0) begin
      fails++;
      $display("FAIL restart_extends: got %0d on cycles after first timeout, want > 0", on_late);
    end
    tick();
    bus.done = 1'b0;
  endtask

  task automatic test_reset_mid();
    int idx;
    bus.cleaning  = 1'b1;
    bus.countdown = 8'd200;
    repeat (20) tick();
    bus.countdown = 8'd239;
    repeat (6) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.seg_out, bus.seg_en, bus.buzzer} !== 13'd0) begin
      fails++;
      $display("FAIL reset_immediate: got seg_out=%h seg_en=%b buzzer=%b, want all 0",
               bus.seg_out, bus.seg_en, bus.buzzer);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.seg_out, bus.seg_en, bus.buzzer} !== 13'd0) begin
        fails++;
        $display("FAIL reset_hold: got seg_out=%h seg_en=%b buzzer=%b, want all 0",
                 bus.seg_out, bus.seg_en, bus.buzzer);
      end
    end
    tick();
    rst = 1'b0;
    bus.countdown = 8'd90;
    cur_cd = 90;
    repeat (20) tick();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      idx = idx_of(bus.seg_en);
      checks++;
      if (idx < 0 || bus.seg_out !== exp_run(90, idx)) begin
        fails++;
        $display("FAIL reset_recover: got seg_en=%b seg_out=%h, want 0.1.30 digit %0d",
                 bus.seg_en, bus.seg_out, idx);
      end
    end
    tick();
  endtask

  initial begin
    bus.cleaning  = 1'b0;
    bus.countdown = 8'd0;
    bus.done      = 1'b0;
    test_reset();
    test_run_values();
    test_scan();
    test_glitch();
    test_random();
    test_done_show();
    test_done_cancel();
    test_done_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
